inst_fetch_unit: RTL and testbench

- Front-end stage directly upstream of the instruction decode/control logic.
- Holds the PC and fetches instruction words from instruction memory over a req/ack handshake.
- Presents each instruction, its PC and its opcode/funct fields to decode under a valid/ready handshake.
- Computes the next PC from decode's branch-taken and jump indications.

---
 rtl/inst_fetch_unit.sv | 118 +++++++++++
 tb/tb_inst_fetch_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: holds the PC, fetches one word at a time
// from instruction memory (req/ack) and hands it to decode (valid/ready).
// The next PC is chosen when decode consumes the instruction.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_ack,
  input  logic [31:0]          imem_rdata,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [31:0]          inst_out,
  output logic [31:0]          pc_out,
  output logic [5:0]           opcode_out,
  output logic [5:0]           funccode_out,
  input  logic                 branch_taken,
  input  logic                 jump,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  // A misaligned reset PC could never be fetched correctly, so refuse it.
  generate
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
      $error("inst_fetch_unit: RESET_PC must be word aligned");
    end
  endgenerate

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                 state_reg, state_next;
  logic [31:0]            pc_reg, pc_next;
  logic [31:0]            inst_reg, inst_next;
  logic [CNT_WIDTH-1:0]   count_reg, count_next;
  logic                   req_int;
  logic                   valid_int;

  // Candidate next-PC values, all derived from the held instruction.
  logic [31:0] pc_seq;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] branch_offset;

  assign pc_seq        = pc_reg + 32'd4;
  assign branch_offset = {{14{inst_reg[15]}}, inst_reg[15:0], 2'b00};
  assign branch_target = pc_seq + branch_offset;
  assign jump_target   = {pc_seq[31:28], inst_reg[25:0], 2'b00};

  // State, PC, instruction and retire counter; reset abandons any fetch in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= FETCH;
      pc_reg    <= RESET_PC;
      inst_reg  <= 32'h0000_0000;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      inst_reg  <= inst_next;
      count_reg <= count_next;
    end
  end

  // Next-state and handshake decode. Acks seen in HOLD are ignored, and the
  // branch/jump inputs only matter in the cycle decode consumes.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    inst_next  = inst_reg;
    count_next = count_reg;
    req_int    = 1'b0;
    valid_int  = 1'b0;
    case (state_reg)
      FETCH: begin
        req_int = 1'b1;
        if (imem_ack) begin
          inst_next  = imem_rdata;
          state_next = HOLD;
        end
      end
      HOLD: begin
        valid_int = 1'b1;
        if (inst_ready) begin
          if (jump) begin
            pc_next = jump_target;
          end else if (branch_taken) begin
            pc_next = branch_target;
          end else begin
            pc_next = pc_seq;
          end
          count_next = count_reg + CNT_WIDTH'(1);
          state_next = FETCH;
        end
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // Handshake outputs are forced low while reset is held so that neither
  // memory nor decode sees activity before the first post-reset cycle.
  assign imem_req     = req_int & ~rst;
  assign inst_valid   = valid_int & ~rst;
  assign imem_addr    = pc_reg;
  assign pc_out       = pc_reg;
  assign inst_out     = inst_reg;
  assign opcode_out   = inst_reg[31:26];
  assign funccode_out = inst_reg[5:0];
  assign fetch_count  = count_reg;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios for the PC
// arithmetic corners, then randomized memory latency, backpressure and
// branch/jump traffic, all checked every cycle against a transaction model.
module tb_inst_fetch_unit;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_rdata = 32'h0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [31:0]   inst_out;
  logic [31:0]   pc_out;
  logic [5:0]    opcode_out;
  logic [5:0]    funccode_out;
  logic          branch_taken = 1'b0;
  logic          jump = 1'b0;
  logic [CW-1:0] fetch_count;

  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst_out     (inst_out),
    .pc_out       (pc_out),
    .opcode_out   (opcode_out),
    .funccode_out (funccode_out),
    .branch_taken (branch_taken),
    .jump         (jump),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Transaction-level model: where we are, which PC, which word, how many retired.
  bit          m_hold = 1'b0;
  logic [31:0] m_pc   = 32'h0;
  logic [31:0] m_inst = 32'h0;
  int          m_cnt  = 0;
  int          consumes = 0;

  // Pending literal expectations, checked at the next sample point.
  bit          pend_addr = 1'b0;
  logic [31:0] pend_addr_val = 32'h0;
  bit          pend_cnt = 1'b0;
  logic [31:0] pend_cnt_val = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Architectural next-PC rule: jump > branch > sequential, all modulo 2^32.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] inst,
                                           input bit j, input bit b);
    logic [31:0] seq;
    logic [31:0] off;
    seq = pc + 32'd4;
    off = 32'($signed(inst[15:0])) * 32'd4;
    if (j) return {seq[31:28], inst[25:0], 2'b00};
    if (b) return seq + off;
    return seq;
  endfunction

  // Compare every visible output with the model (called at each negedge).
  task automatic sample_check();
    chk("imem_req", {31'b0, imem_req}, {31'b0, !m_hold});
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_hold});
    chk("pc_out", pc_out, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("fetch_count", {28'b0, fetch_count}, 32'(m_cnt % (1 << CW)));
    if (m_hold) begin
      chk("inst_out", inst_out, m_inst);
      chk("opcode_out", {26'b0, opcode_out}, {26'b0, m_inst[31:26]});
      chk("funccode_out", {26'b0, funccode_out}, {26'b0, m_inst[5:0]});
    end
    if (pend_addr) begin
      chk("next_addr_literal", imem_addr, pend_addr_val);
      pend_addr = 1'b0;
    end
    if (pend_cnt) begin
      chk("count_literal", {28'b0, fetch_count}, pend_cnt_val);
      pend_cnt = 1'b0;
    end
  endtask

  // One full instruction: wt wait cycles before ack, stall cycles of
  // inst_ready=0 before consume, then j/b applied on the consume cycle.
  task automatic run_item(input logic [31:0] inst, input int wt, input int stall,
                          input bit j, input bit b, input bit has_exp, input logic [31:0] exp_addr);
    logic [31:0] nxt;
    for (int w = 0; w <= wt; w++) begin
      @(negedge clk);
      sample_check();
      imem_ack     = (w == wt);
      imem_rdata   = (w == wt) ? inst : $urandom;
      inst_ready   = 1'($urandom);
      jump         = 1'($urandom);
      branch_taken = 1'($urandom);
      if (w == wt) begin
        m_hold = 1'b1;
        m_inst = inst;
      end
    end
    for (int s = 0; s <= stall; s++) begin
      @(negedge clk);
      sample_check();
      imem_ack     = 1'($urandom);
      imem_rdata   = $urandom;
      inst_ready   = (s == stall);
      jump         = (s == stall) ? j : 1'($urandom);
      branch_taken = (s == stall) ? b : 1'($urandom);
      if (s == stall) begin
        nxt = ref_next(m_pc, m_inst, j, b);
        $display("txn %0d pc=%h inst=%h wait=%0d stall=%0d j=%0b b=%0b next=%h",
                 consumes, m_pc, m_inst, wt, stall, j, b, nxt);
        m_pc   = nxt;
        m_cnt  = m_cnt + 1;
        m_hold = 1'b0;
        consumes++;
        if (has_exp) begin
          pend_addr     = 1'b1;
          pend_addr_val = exp_addr;
        end
        if (consumes == 3) begin
          pend_cnt     = 1'b1;
          pend_cnt_val = 32'd3;
        end
        if (consumes == 16) begin
          pend_cnt     = 1'b1;
          pend_cnt_val = 32'd0;
        end
      end
    end
  endtask

  task automatic run_random(input int n);
    for (int k = 0; k < n; k++) begin
      run_item($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 1'b0, 32'h0);
    end
  endtask

  initial begin
    // Reset state while rst is held.
    @(negedge clk);
    chk("reset_imem_req", {31'b0, imem_req}, 32'h0);
    chk("reset_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("reset_pc_out", pc_out, 32'h0);
    chk("reset_inst_out", inst_out, 32'h0);
    chk("reset_fetch_count", {28'b0, fetch_count}, 32'h0);
    rst = 1'b0;

    // Sequential zero-wait fetch, then wait states with backpressure.
    run_item(32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0004);
    run_item(32'h0000_0021, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0008);
    run_item(32'h0000_0022, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_000C);
    run_item(32'h0000_0024, 3, 4, 1'b0, 1'b0, 1'b1, 32'h0000_0010);
    // Jump to 0x100, branch back by -2 words, then not-taken.
    run_item(32'h0800_0040, 0, 0, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
    run_item(32'h1000_FFFE, 1, 1, 1'b0, 1'b1, 1'b1, 32'h0000_00FC);
    run_item(32'h1000_FFFE, 0, 2, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
    // Branch below zero, then wrap sequentially to zero.
    run_item(32'h1000_FFBE, 2, 0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    run_item(32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0000);
    // Into the top region, then jump with branch also asserted.
    run_item(32'h1000_8000, 0, 0, 1'b0, 1'b1, 1'b1, 32'hFFFE_0004);
    run_item(32'h0800_0040, 1, 0, 1'b1, 1'b1, 1'b1, 32'hF000_0100);
    // Fill up to 16 consumes so the 4-bit counter wraps to zero.
    for (int k = 0; k < 5; k++) begin
      run_item($urandom, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
    end

    run_random(200);

    // Async reset while holding an instruction, mid clock-low phase.
    @(negedge clk);
    sample_check();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    inst_ready = 1'b0;
    m_hold     = 1'b1;
    m_inst     = 32'hDEAD_BEEF;
    @(negedge clk);
    sample_check();
    imem_ack   = 1'b0;
    inst_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("async_imem_req", {31'b0, imem_req}, 32'h0);
    chk("async_pc_out", pc_out, 32'h0);
    chk("async_inst_out", inst_out, 32'h0);
    @(negedge clk);
    rst    = 1'b0;
    m_hold = 1'b0;
    m_pc   = 32'h0;
    m_inst = 32'h0;
    m_cnt  = 0;
    run_item(32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0004);
    run_random(30);

    @(negedge clk);
    sample_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
